alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the processor's combinational 16-bit ALU.
- Adds a start/busy/done handshake and registered results.
- Adds iterative shifts (one bit per cycle) and a shift-add multiply.
- Adds carry and overflow flags alongside zero and negative.
- Sits in the execute stage of the multi-cycle datapath; the control FSM holds in its execute state until output_done.

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_flag_gen.sv | 44 ++++
 rtl/alu_seq.sv | 218 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode, state and latency definitions shared by the sequential ALU
//   Contents: opcode constants OP_ADD..OP_MUL, state_t (ST_IDLE/ST_RUN),
//             latency(op, amt, width) returning the number of RUN edges.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_SRL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Edges spent in RUN after the start edge. A zero-amount shift still takes
  // one edge so every operation produces exactly one done pulse.
  function automatic int unsigned latency(input logic [3:0] op,
                                          input int unsigned amt,
                                          input int unsigned width);
    int unsigned n;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: n = (amt == 0) ? 1 : amt;
      OP_MUL:                 n = width;
      default:                n = 1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational zero/negative/carry/overflow generation
//   Inputs : op (4b), a, b (operands), res (raw WIDTH-bit result), raw_carry
//   Outputs: zero, negative, carry, overflow
module alu_flag_gen
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] res,
  input  logic             raw_carry,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  logic sa, sb, sr;

  always_comb begin
    sa       = a[WIDTH-1];
    sb       = b[WIDTH-1];
    sr       = res[WIDTH-1];
    zero     = (res == '0);
    negative = sr;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        carry    = raw_carry;
        overflow = (sa == sb) && (sr != sa);
      end
      OP_SUB: begin
        carry    = raw_carry;
        overflow = (sa != sb) && (sr != sa);
      end
      OP_SLL, OP_SRL, OP_SRA, OP_MUL: carry = raw_carry;
      default: carry = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with start/busy/done handshake
//   Inputs : input_clk, input_reset (sync, active high), input_start,
//            input_A, input_B (low SHW bits = shift amount), input_ALUOp
//   Outputs: output_ALU, output_Zero, output_negative, output_carry,
//            output_overflow (all registered, updated only on done),
//            output_busy (state == RUN), output_done (one-cycle pulse)
//   OP_W must be at least 4; opcodes with any bit above bit 3 set are invalid.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             input_clk,
  input  logic             input_reset,
  input  logic             input_start,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic [OP_W-1:0]  input_ALUOp,
  output logic [WIDTH-1:0] output_ALU,
  output logic             output_Zero,
  output logic             output_negative,
  output logic             output_carry,
  output logic             output_overflow,
  output logic             output_busy,
  output logic             output_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]     alu_q, alu_d;
  logic                 zero_q, zero_d, neg_q, neg_d;
  logic                 carry_q, carry_d, ovf_q, ovf_d, done_q, done_d;

  logic [3:0]           op_in;
  logic [SHW-1:0]       amt_in, amt_q;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     shift_next;
  logic                 shift_out;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     raw_res;
  logic                 raw_carry;
  logic                 f_zero, f_neg, f_carry, f_ovf;

  // Collapse wider opcode buses onto the 4-bit internal opcode; anything
  // beyond 15 lands on 0xF, which is invalid.
  always_comb begin
    op_in = input_ALUOp[3:0];
    if ((input_ALUOp >> 4) != '0) op_in = 4'hF;
  end

  assign amt_in = input_B[SHW-1:0];
  assign amt_q  = b_q[SHW-1:0];

  // Datapath for one RUN step and for the final result.
  always_comb begin
    sum        = {1'b0, a_q} + {1'b0, b_q};
    shift_next = work_q;
    shift_out  = 1'b0;
    case (op_q)
      OP_SLL: begin
        shift_next = work_q << 1;
        shift_out  = work_q[WIDTH-1];
      end
      OP_SRL: begin
        shift_next = work_q >> 1;
        shift_out  = work_q[0];
      end
      OP_SRA: begin
        shift_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        shift_out  = work_q[0];
      end
      default: ;
    endcase
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    raw_res   = '0;
    raw_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        raw_res   = sum[WIDTH-1:0];
        raw_carry = sum[WIDTH];
      end
      OP_SUB: begin
        raw_res   = a_q - b_q;
        raw_carry = (a_q < b_q);
      end
      OP_AND: raw_res = a_q & b_q;
      OP_OR:  raw_res = a_q | b_q;
      OP_XOR: raw_res = a_q ^ b_q;
      OP_SLL, OP_SRL, OP_SRA: begin
        // Final step performs the last shift; amt==0 passes A straight through.
        raw_res   = (amt_q == '0) ? work_q : shift_next;
        raw_carry = (amt_q == '0) ? 1'b0 : shift_out;
      end
      OP_MUL: begin
        raw_res   = acc_step[WIDTH-1:0];
        raw_carry = (acc_step[2*WIDTH-1:WIDTH] != '0);
      end
      default: ;
    endcase
  end

  alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .res       (raw_res),
    .raw_carry (raw_carry),
    .zero      (f_zero),
    .negative  (f_neg),
    .carry     (f_carry),
    .overflow  (f_ovf)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    alu_d    = alu_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (input_start) begin
          state_d  = ST_RUN;
          op_d     = op_in;
          a_d      = input_A;
          b_d      = input_B;
          work_d   = input_A;
          mplier_d = input_B;
          mcand_d  = {{WIDTH{1'b0}}, input_A};
          acc_d    = '0;
          cnt_d    = CNT_W'(latency(op_in, 32'(amt_in), 32'(WIDTH)));
        end
      end
      ST_RUN: begin
        cnt_d    = cnt_q - CNT_W'(1);
        work_d   = shift_next;
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          alu_d   = raw_res;
          zero_d  = f_zero;
          neg_d   = f_neg;
          carry_d = f_carry;
          ovf_d   = f_ovf;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge input_clk) begin
    if (input_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      alu_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      alu_q    <= alu_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign output_ALU      = alu_q;
  assign output_Zero     = zero_q;
  assign output_negative = neg_q;
  assign output_carry    = carry_q;
  assign output_overflow = ovf_q;
  assign output_busy     = (state_q == ST_RUN);
  assign output_done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

  logic        input_clk = 1'b0;
  logic        input_reset = 1'b1;
  logic        input_start = 1'b0;
  logic [15:0] input_A = '0;
  logic [15:0] input_B = '0;
  logic [3:0]  input_ALUOp = '0;
  logic [15:0] output_ALU;
  logic        output_Zero, output_negative, output_carry, output_overflow;
  logic        output_busy, output_done;

  int n_checks = 0;
  int n_fail = 0;

  // Last committed outputs as the model sees them: {alu, zero, neg, carry, ovf}
  logic [19:0] exp_last = '0;

  alu_seq #(.WIDTH(16), .OP_W(4)) dut (
    .input_clk       (input_clk),
    .input_reset     (input_reset),
    .input_start     (input_start),
    .input_A         (input_A),
    .input_B         (input_B),
    .input_ALUOp     (input_ALUOp),
    .output_ALU      (output_ALU),
    .output_Zero     (output_Zero),
    .output_negative (output_negative),
    .output_carry    (output_carry),
    .output_overflow (output_overflow),
    .output_busy     (output_busy),
    .output_done     (output_done)
  );

  always #5 input_clk = ~input_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] dut_out();
    return {output_ALU, output_Zero, output_negative, output_carry, output_overflow};
  endfunction

  // Reference: result, flags and latency straight from the operation definitions.
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [19:0] exp, output int lat);
    logic [31:0] full;
    logic [15:0] r;
    logic        c, v;
    int          amt;
    amt  = int'(b[3:0]);
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    lat  = 1;
    case (op)
      4'd0: begin
        full = 32'(a) + 32'(b);
        r = full[15:0]; c = full[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd1: begin
        r = a - b; c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd2: begin
        full = 32'(a) << amt; r = full[15:0];
        c = (amt == 0) ? 1'b0 : a[16-amt];
        lat = (amt == 0) ? 1 : amt;
      end
      4'd3: begin
        r = a >> amt; c = (amt == 0) ? 1'b0 : a[amt-1];
        lat = (amt == 0) ? 1 : amt;
      end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: begin
        r = 16'($signed(a) >>> amt); c = (amt == 0) ? 1'b0 : a[amt-1];
        lat = (amt == 0) ? 1 : amt;
      end
      4'd8: begin
        full = 32'(a) * 32'(b);
        r = full[15:0]; c = (full[31:16] != 0);
        lat = 16;
      end
      default: r = '0;
    endcase
    exp = {r, (r == 16'h0), r[15], c, v};
  endtask

  // Issue one operation, scramble the operand inputs after the start edge and
  // follow it to done, checking latency, busy, output hold and final values.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b);
    logic [19:0] exp;
    int          lat, cyc;
    bit          got, busy_ok, hold_ok;
    model(op, a, b, exp, lat);
    @(negedge input_clk);
    input_ALUOp = op; input_A = a; input_B = b; input_start = 1'b1;
    @(posedge input_clk); #1;
    input_start = 1'b0;
    input_A = 16'($urandom); input_B = 16'($urandom); input_ALUOp = 4'($urandom);
    cyc = 0; got = 0; busy_ok = 1; hold_ok = 1;
    while (!got && cyc < 40) begin
      if (!output_busy || output_done) busy_ok = 0;
      if (dut_out() !== exp_last) hold_ok = 0;
      @(posedge input_clk); #1;
      cyc++;
      if (output_done) got = 1;
    end
    chk({tag, "_done"}, 64'(got), 64'd1);
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(output_busy), 64'd0);
    chk({tag, "_result"}, 64'(dut_out()), 64'(exp));
    exp_last = exp;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge input_clk); #1;
    chk({tag, "_done_drop"}, 64'(output_done), 64'd0);
    chk({tag, "_idle"}, 64'(output_busy), 64'd0);
  endtask

  initial begin
    bit saw_done;
    input_reset = 1'b1;
    repeat (2) @(posedge input_clk);
    #1;
    chk("reset_outs", 64'(dut_out()), 64'd0);
    chk("reset_busy", 64'(output_busy), 64'd0);
    chk("reset_done", 64'(output_done), 64'd0);
    input_reset = 1'b0;

    run_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001);
    chk("add_ovf_val", 64'(output_ALU), 64'h8000);
    idle_cycle("add_ovf");
    run_op("sub_borrow", 4'd1, 16'h0003, 16'h0005);
    chk("sub_borrow_val", 64'(output_ALU), 64'hFFFE);
    run_op("sub_ovf", 4'd1, 16'h8000, 16'h0001);
    chk("sub_ovf_flag", 64'(output_overflow), 64'd1);
    run_op("sra4", 4'd7, 16'h8008, 16'h0004);
    chk("sra4_val", 64'(output_ALU), 64'hF800);
    run_op("sll0", 4'd2, 16'h1234, 16'h0000);
    chk("sll0_val", 64'(output_ALU), 64'h1234);
    run_op("srl15", 4'd3, 16'h8001, 16'h000F);
    run_op("mul_small", 4'd8, 16'h00FF, 16'h0003);
    chk("mul_small_val", 64'(output_ALU), 64'h02FD);
    run_op("mul_wrap", 4'd8, 16'h0100, 16'h0100);
    chk("mul_wrap_flags", 64'({output_Zero, output_carry}), 64'b11);
    run_op("invalid", 4'hF, 16'hFFFF, 16'h1234);
    chk("invalid_zero", 64'(output_Zero), 64'd1);
    run_op("b2b_add", 4'd0, 16'hFFFF, 16'h0001);

    // MUL aborted by reset; a start while busy must be ignored.
    @(negedge input_clk);
    input_ALUOp = 4'd8; input_A = 16'h1234; input_B = 16'h5678; input_start = 1'b1;
    @(posedge input_clk); #1;                 // edge 0
    input_start = 1'b0;
    saw_done = 0;
    repeat (4) begin
      @(posedge input_clk); #1;               // edges 1..4
      if (output_done) saw_done = 1;
    end
    @(negedge input_clk);
    input_ALUOp = 4'd0; input_A = 16'd1; input_B = 16'd1; input_start = 1'b1;
    @(posedge input_clk); #1;                 // edge 5
    input_start = 1'b0;
    chk("busy_ignore_start", 64'(output_busy), 64'd1);
    repeat (2) begin
      @(posedge input_clk); #1;               // edges 6, 7
      if (output_done) saw_done = 1;
    end
    input_reset = 1'b1;
    @(posedge input_clk); #1;                 // edge 8
    input_reset = 1'b0;
    chk("abort_outs", 64'(dut_out()), 64'd0);
    chk("abort_busy", 64'(output_busy), 64'd0);
    repeat (20) begin
      @(posedge input_clk); #1;
      if (output_done || output_busy) saw_done = 1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    exp_last = '0;
    run_op("add_after_rst", 4'd0, 16'd2, 16'd3);
    chk("add_after_rst_val", 64'(output_ALU), 64'h0005);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    end
    idle_cycle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
